// File: rtl/hrv_pkg.sv
// Shared HRV datapath constants: RR interval width, tick defaults and the
// interval-timer state encoding, common to the RR timer and the RMSSD stage.
package hrv_pkg;

    localparam int RR_W              = 8;
    localparam int DEF_CLK_DIV       = 80000;
    localparam int DEF_REFRACT_TICKS = 25;
    localparam int DEF_PRE_W         = 17;

    localparam logic [RR_W-1:0] RR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } hrv_state_e;

endpackage

// File: rtl/hrv_beat_sync.sv
// Brings the asynchronous R-peak pulse into the clk domain and turns each
// rising edge into a single-cycle beat event.
module hrv_beat_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_in,
    output logic beat_evt
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // sync3_q is the previous synchronised level, used only for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= beat_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign beat_evt = sync2_q & ~sync3_q;

endmodule

// File: rtl/hrv_rr_timer.sv
// R-peak to RR-interval converter: tick prescaler, interval counter with
// refractory rejection and lost-beat timeout, registered output strobes.
module hrv_rr_timer
    import hrv_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int REFRACT_TICKS = DEF_REFRACT_TICKS,
    parameter int PRE_W         = DEF_PRE_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            beat_in,
    output logic [RR_W-1:0] rr_out,
    output logic            rr_valid,
    output logic            artifact,
    output logic            timeout,
    output logic [RR_W-1:0] beat_cnt
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [RR_W-1:0]  REFRACT  = RR_W'(REFRACT_TICKS);

    logic beat_evt;
    logic tick;

    hrv_state_e      state_q,    state_d;
    logic [PRE_W-1:0] pre_q,     pre_d;
    logic [RR_W-1:0] rr_cnt_q,   rr_cnt_d;
    logic [RR_W-1:0] rr_out_q,   rr_out_d;
    logic [RR_W-1:0] beat_cnt_q, beat_cnt_d;
    logic            rr_valid_q, rr_valid_d;
    logic            artifact_q, artifact_d;
    logic            timeout_q,  timeout_d;

    hrv_beat_sync u_beat_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat_in  (beat_in),
        .beat_evt (beat_evt)
    );

    assign tick = (pre_q == PRE_LAST);

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        rr_cnt_d   = rr_cnt_q;
        rr_out_d   = rr_out_q;
        beat_cnt_d = beat_cnt_q;
        rr_valid_d = 1'b0;
        artifact_d = 1'b0;
        timeout_d  = 1'b0;

        if (!en) begin
            state_d  = ST_IDLE;
            pre_d    = '0;
            rr_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ARM;
                    pre_d    = '0;
                    rr_cnt_d = '0;
                end
                ST_ARM: begin
                    pre_d    = '0;
                    rr_cnt_d = '0;
                    if (beat_evt) begin
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    // An accepted beat takes priority over a coincident tick or timeout
                    if (beat_evt && (rr_cnt_q >= REFRACT)) begin
                        rr_out_d   = rr_cnt_q;
                        rr_valid_d = 1'b1;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        rr_cnt_d   = '0;
                        pre_d      = '0;
                    end else begin
                        artifact_d = beat_evt;
                        if (tick) begin
                            if (rr_cnt_q == RR_MAX) begin
                                timeout_d = 1'b1;
                                state_d   = ST_ARM;
                                rr_cnt_d  = '0;
                                pre_d     = '0;
                            end else begin
                                rr_cnt_d = rr_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    pre_d    = '0;
                    rr_cnt_d = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            rr_cnt_q   <= '0;
            rr_out_q   <= '0;
            beat_cnt_q <= '0;
            rr_valid_q <= 1'b0;
            artifact_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            rr_cnt_q   <= rr_cnt_d;
            rr_out_q   <= rr_out_d;
            beat_cnt_q <= beat_cnt_d;
            rr_valid_q <= rr_valid_d;
            artifact_q <= artifact_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rr_out   = rr_out_q;
    assign rr_valid = rr_valid_q;
    assign artifact = artifact_q;
    assign timeout  = timeout_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_hrv_rr_timer.sv
// Scoreboard bench for hrv_rr_timer: beat timing model computes each
// expected strobe from beat arrival times; a monitor matches DUT strobes.
module tb_hrv_rr_timer;

    localparam int C   = 4;
    localparam int REF = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       beat_in = 1'b0;
    logic [7:0] rr_out;
    logic       rr_valid;
    logic       artifact;
    logic       timeout;
    logic [7:0] beat_cnt;

    always #5 clk = ~clk;

    hrv_rr_timer #(
        .CLK_DIV       (C),
        .REFRACT_TICKS (REF),
        .PRE_W         (17)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .beat_in  (beat_in),
        .rr_out   (rr_out),
        .rr_valid (rr_valid),
        .artifact (artifact),
        .timeout  (timeout),
        .beat_cnt (beat_cnt)
    );

    localparam int K_VALID = 0;
    localparam int K_ART   = 1;
    localparam int K_TO    = 2;

    typedef struct {
        int kind;
        int rr;
        int cnt;
        int cyc;
    } exp_t;

    typedef enum { M_IDLE, M_ARM, M_MEAS } mstate_e;

    exp_t    sb[$];
    int      evt_q[$];
    int      cyc       = 0;
    int      n_checks  = 0;
    int      n_fail    = 0;
    int      last_rise = 0;
    int      last_fall = 0;
    mstate_e m_state   = M_IDLE;
    int      t0        = 0;
    int      m_cnt     = 0;
    int      m_rr      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int kind, input int rr, input int cnt, input int at);
        exp_t x;
        x.kind = kind;
        x.rr   = rr;
        x.cnt  = cnt;
        x.cyc  = at;
        sb.push_back(x);
    endfunction

    // Reference model: beat event lands 3 edges after the pulse rises; the
    // interval is the number of whole ticks elapsed since the accepted beat.
    always @(posedge clk) begin
        bit evt;
        int rr;
        cyc++;
        evt = 1'b0;
        while (evt_q.size() > 0 && evt_q[0] < cyc) void'(evt_q.pop_front());
        if (evt_q.size() > 0 && evt_q[0] == cyc) begin
            evt = 1'b1;
            void'(evt_q.pop_front());
        end
        if (!rst_n) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_rr    = 0;
        end else if (!en) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: m_state = M_ARM;
                M_ARM: begin
                    if (evt) begin
                        m_state = M_MEAS;
                        t0      = cyc;
                    end
                end
                default: begin
                    if (evt) begin
                        rr = (cyc - t0 - 1) / C;
                        if (rr < REF) begin
                            push_exp(K_ART, m_rr, m_cnt, cyc);
                        end else begin
                            m_rr  = rr;
                            m_cnt = (m_cnt + 1) % 256;
                            t0    = cyc;
                            push_exp(K_VALID, m_rr, m_cnt, cyc);
                        end
                    end else if (cyc - t0 == 256 * C) begin
                        push_exp(K_TO, m_rr, m_cnt, cyc);
                        m_state = M_ARM;
                    end
                end
            endcase
        end
    end

    // Monitor: any strobe pops the oldest expectation; an overdue one is a miss.
    always @(negedge clk) begin
        exp_t x;
        int   kind;
        if (rst_n) begin
            if (rr_valid || artifact || timeout) begin
                check("strobe_onehot", 32'(rr_valid) + 32'(artifact) + 32'(timeout), 1);
                kind = rr_valid ? K_VALID : (artifact ? K_ART : K_TO);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", kind, cyc);
                end else begin
                    x = sb.pop_front();
                    check("strobe_cycle", cyc, x.cyc);
                    check("strobe_kind", kind, x.kind);
                    check("rr_out", {24'd0, rr_out}, x.rr);
                    check("beat_cnt", {24'd0, beat_cnt}, x.cnt);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                x = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_strobe: got none expected kind %0d rr %0d (cycle %0d)", x.kind, x.rr, x.cyc);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse beat_in high for 3 clocks, rising `gap` cycles after the last rise.
    task automatic beat(input int gap);
        while (cyc < last_rise + gap || cyc < last_fall + 2) wait_cycles(1);
        beat_in   = 1'b1;
        last_rise = cyc;
        evt_q.push_back(cyc + 3);
        wait_cycles(3);
        beat_in   = 1'b0;
        last_fall = cyc;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish expected finish by 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        wait_cycles(3);
        rst_n = 1'b1;
        check("reset_rr_out", {24'd0, rr_out}, 0);
        check("reset_beat_cnt", {24'd0, beat_cnt}, 0);
        check("reset_rr_valid", 32'(rr_valid), 0);
        check("reset_artifact", 32'(artifact), 0);
        check("reset_timeout", 32'(timeout), 0);

        // Disabled: beats must produce nothing
        beat(0); beat(20); beat(20);
        wait_cycles(5);
        en = 1'b1;
        wait_cycles(2);

        // Basic, tie, refractory, coincident timeout
        beat(50); beat(41); beat(41);
        beat(60); beat(40);
        beat(60); beat(9); beat(32);
        beat(1024);

        // Lost beat: timeout then re-arm
        beat(20);
        wait_cycles(1100);
        beat(1); beat(41);

        // Async reset mid-interval
        beat(30); beat(50);
        wait_cycles(20);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rr_out", {24'd0, rr_out}, 0);
        check("rst_mid_beat_cnt", {24'd0, beat_cnt}, 0);
        check("rst_mid_strobes", {29'd0, rr_valid, artifact, timeout}, 0);
        sb.delete();
        evt_q.delete();
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);

        // 256 valid intervals wrap the count back to zero
        beat(10);
        for (int i = 0; i < 256; i++) beat($urandom_range(13, 40));
        check("wrap_beat_cnt", {24'd0, beat_cnt}, 0);

        // Disable: outputs hold, beats ignored
        r = m_rr;
        en = 1'b0;
        wait_cycles(5);
        beat(10); beat(20);
        wait_cycles(5);
        check("hold_rr_out", {24'd0, rr_out}, r);
        check("hold_beat_cnt", {24'd0, beat_cnt}, 0);

        // Randomised traffic with occasional enable drops and lost beats
        en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                en = 1'b0;
                wait_cycles($urandom_range(1, 5));
                en = 1'b1;
            end
            if (r == 1)      beat($urandom_range(1020, 1100));
            else if (r < 6)  beat($urandom_range(6, 15));
            else             beat($urandom_range(12, 80));
        end

        wait_cycles(20);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
